// File: rtl/ready_sync_if.sv
// rtl/ready_sync_if.sv - player/control handshake bundle for ready_sync
interface ready_sync_if #(
    parameter int NPLAYER = 2,
    parameter int NUM_W   = 4
);
    logic [NPLAYER-1:0] READY;
    logic               CLR;
    logic [NUM_W-1:0]   NUM;
    logic [NPLAYER-1:0] OK;
    logic [NPLAYER-1:0] LED;
    logic               ALL_READY;
    logic               TIMEOUT;

    modport master (
        output READY,
        output CLR,
        input  NUM,
        input  OK,
        input  LED,
        input  ALL_READY,
        input  TIMEOUT
    );

    modport slave (
        input  READY,
        input  CLR,
        output NUM,
        output OK,
        output LED,
        output ALL_READY,
        output TIMEOUT
    );
endinterface

// File: rtl/ready_sync.sv
// rtl/ready_sync.sv - collects per-player ready presses and deals one shared rolled number
module ready_sync #(
    parameter int NPLAYER       = 2,
    parameter int NUM_W         = 4,
    parameter int NUM_MAX       = 9,
    parameter int TICK_DIV      = 5000000,
    parameter int TIMEOUT_TICKS = 100,
    parameter int HOLD_MODE     = 1
) (
    input  logic         CLK,
    input  logic         RST,
    ready_sync_if.slave  bus
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W   = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [NUM_W-1:0]  ROLL_LAST = NUM_W'(NUM_MAX - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DEAL  = 2'd2
    } state_t;

    state_t             r_state;
    logic [NPLAYER-1:0] r_latch;
    logic [NPLAYER-1:0] r_led;
    logic [TICK_W-1:0]  r_tick;
    logic [NUM_W-1:0]   r_roll;
    logic [TO_W-1:0]    r_to_cnt;
    logic [NUM_W-1:0]   r_num;
    logic [NPLAYER-1:0] r_ok;
    logic               r_all_ready;
    logic               r_timeout;

    logic               w_tick;
    logic               w_all;
    logic               w_to_hit;
    logic [NPLAYER-1:0] w_latch_next;

    assign w_tick       = (r_tick == TICK_LAST);
    assign w_all        = &r_latch;
    assign w_to_hit     = (TIMEOUT_TICKS != 0) && (r_to_cnt == TO_LIMIT);
    // CLR beats a press arriving in the same cycle
    assign w_latch_next = bus.CLR ? '0 : (r_latch | bus.READY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick <= '0;
            r_roll <= '0;
        end else begin
            r_tick <= w_tick ? '0 : r_tick + TICK_W'(1);
            if (w_tick && (r_state != ST_DEAL)) begin
                r_roll <= (r_roll == ROLL_LAST) ? '0 : r_roll + NUM_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_latch     <= '0;
            r_led       <= '0;
            r_to_cnt    <= '0;
            r_num       <= '0;
            r_ok        <= '0;
            r_all_ready <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_led     <= r_latch;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt    <= '0;
                    r_latch     <= w_latch_next;
                    r_num       <= '0;
                    r_ok        <= '0;
                    r_all_ready <= 1'b0;
                    // arm in the same edge the first latch sets, so press-to-deal stays two cycles
                    if (|w_latch_next) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bus.CLR || (r_latch == '0)) begin
                        r_latch <= w_latch_next;
                        r_state <= ST_IDLE;
                    end else if (w_all) begin
                        r_num       <= r_roll + NUM_W'(1);
                        r_ok        <= '1;
                        r_all_ready <= 1'b1;
                        r_state     <= ST_DEAL;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_latch   <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_latch <= w_latch_next;
                        if (w_tick) begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                end
                ST_DEAL: begin
                    if ((HOLD_MODE == 0) || bus.CLR) begin
                        r_num       <= '0;
                        r_ok        <= '0;
                        r_all_ready <= 1'b0;
                        r_latch     <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_latch     <= '0;
                    r_num       <= '0;
                    r_ok        <= '0;
                    r_all_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.NUM       = r_num;
    assign bus.OK        = r_ok;
    assign bus.LED       = r_led;
    assign bus.ALL_READY = r_all_ready;
    assign bus.TIMEOUT   = r_timeout;
endmodule

// File: tb/tb_ready_sync.sv
// tb/tb_ready_sync.sv - directed bench for ready_sync across four parameter sets
module tb_ready_sync;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ready_sync_if #(.NPLAYER(2), .NUM_W(4)) if0 ();
    ready_sync_if #(.NPLAYER(2), .NUM_W(4)) if1 ();
    ready_sync_if #(.NPLAYER(2), .NUM_W(4)) if2 ();
    ready_sync_if #(.NPLAYER(4), .NUM_W(4)) if3 ();

    ready_sync #(.NPLAYER(2), .NUM_W(4), .NUM_MAX(9), .TICK_DIV(4),
                 .TIMEOUT_TICKS(100), .HOLD_MODE(1))
        u0 (.CLK(CLK), .RST(RST), .bus(if0));
    ready_sync #(.NPLAYER(2), .NUM_W(4), .NUM_MAX(9), .TICK_DIV(4),
                 .TIMEOUT_TICKS(100), .HOLD_MODE(0))
        u1 (.CLK(CLK), .RST(RST), .bus(if1));
    ready_sync #(.NPLAYER(2), .NUM_W(4), .NUM_MAX(9), .TICK_DIV(4),
                 .TIMEOUT_TICKS(2), .HOLD_MODE(1))
        u2 (.CLK(CLK), .RST(RST), .bus(if2));
    ready_sync #(.NPLAYER(4), .NUM_W(4), .NUM_MAX(6), .TICK_DIV(1),
                 .TIMEOUT_TICKS(100), .HOLD_MODE(1))
        u3 (.CLK(CLK), .RST(RST), .bus(if3));

    typedef struct {
        logic [1:0] ready;
        logic       clr;
        logic [1:0] ok;
        logic [1:0] led;
        logic [3:0] num;
        logic       all_ready;
    } vec_t;

    vec_t vecs [12];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        if0.READY = '0; if0.CLR = 1'b0;
        if1.READY = '0; if1.CLR = 1'b0;
        if2.READY = '0; if2.CLR = 1'b0;
        if3.READY = '0; if3.CLR = 1'b0;
        repeat (2) step();
        RST = 1'b0;
    endtask

    function automatic vec_t mk(logic [1:0] rd, logic cl, logic [1:0] ok,
                                logic [1:0] led, logic [3:0] num, logic all);
        vec_t v;
        v.ready = rd; v.clr = cl; v.ok = ok; v.led = led; v.num = num; v.all_ready = all;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_to;
        int to_cnt;
        int ok_seen;
        int prev_num;
        int wrap_seen;

        // press 01, press 10 three cycles later, hold, CLR; then READY+CLR together
        vecs[0]  = mk(2'b01, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0);
        vecs[1]  = mk(2'b00, 1'b0, 2'b00, 2'b01, 4'd0, 1'b0);
        vecs[2]  = mk(2'b00, 1'b0, 2'b00, 2'b01, 4'd0, 1'b0);
        vecs[3]  = mk(2'b10, 1'b0, 2'b00, 2'b01, 4'd0, 1'b0);
        vecs[4]  = mk(2'b00, 1'b0, 2'b11, 2'b11, 4'd2, 1'b1);
        vecs[5]  = mk(2'b00, 1'b0, 2'b11, 2'b11, 4'd2, 1'b1);
        vecs[6]  = mk(2'b11, 1'b0, 2'b11, 2'b11, 4'd2, 1'b1);
        vecs[7]  = mk(2'b00, 1'b1, 2'b00, 2'b11, 4'd0, 1'b0);
        vecs[8]  = mk(2'b00, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0);
        vecs[9]  = mk(2'b01, 1'b1, 2'b00, 2'b00, 4'd0, 1'b0);
        vecs[10] = mk(2'b00, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0);
        vecs[11] = mk(2'b00, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0);

        do_reset();
        chk("rst ok0", if0.OK, 0);
        chk("rst num0", if0.NUM, 0);
        chk("rst led0", if0.LED, 0);
        chk("rst all0", if0.ALL_READY, 0);
        chk("rst to0", if0.TIMEOUT, 0);
        chk("rst ok3", if3.OK, 0);
        chk("rst led3", if3.LED, 0);

        for (int i = 0; i < 12; i++) begin
            if0.READY = vecs[i].ready;
            if0.CLR   = vecs[i].clr;
            step();
            chk($sformatf("vec%0d ok", i), if0.OK, vecs[i].ok);
            chk($sformatf("vec%0d led", i), if0.LED, vecs[i].led);
            chk($sformatf("vec%0d num", i), if0.NUM, vecs[i].num);
            chk($sformatf("vec%0d all_ready", i), if0.ALL_READY, vecs[i].all_ready);
            chk($sformatf("vec%0d timeout", i), if0.TIMEOUT, 0);
        end
        if0.READY = '0; if0.CLR = 1'b0;

        // reset during DEAL: roll must restart at 0
        do_reset();
        repeat (8) step();
        if0.READY = 2'b11;
        step();
        if0.READY = 2'b00;
        chk("rd ok before deal", if0.OK, 0);
        step();
        chk("rd ok deal", if0.OK, 2'b11);
        chk("rd num deal", if0.NUM, 3);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rd ok after rst", if0.OK, 0);
        chk("rd num after rst", if0.NUM, 0);
        chk("rd led after rst", if0.LED, 0);
        chk("rd all after rst", if0.ALL_READY, 0);
        if0.READY = 2'b11;
        step();
        if0.READY = 2'b00;
        step();
        chk("rd ok redeal", if0.OK, 2'b11);
        chk("rd num roll0", if0.NUM, 1);
        if0.CLR = 1'b1;
        step();
        if0.CLR = 1'b0;

        // single-cycle deal pulse
        do_reset();
        if1.READY = 2'b11;
        step();
        if1.READY = 2'b00;
        step();
        chk("pulse ok", if1.OK, 2'b11);
        chk("pulse num", if1.NUM, 1);
        chk("pulse all", if1.ALL_READY, 1);
        step();
        chk("pulse ok gone", if1.OK, 0);
        chk("pulse num gone", if1.NUM, 0);
        chk("pulse all gone", if1.ALL_READY, 0);
        step();
        chk("pulse led clear", if1.LED, 0);
        chk("pulse no timeout", if1.TIMEOUT, 0);

        // timeout with only player 0 pressed
        do_reset();
        first_to = 0;
        to_cnt   = 0;
        ok_seen  = 0;
        if2.READY = 2'b01;
        step();
        if2.READY = 2'b00;
        for (int k = 2; k <= 16; k++) begin
            step();
            if (if2.TIMEOUT === 1'b1) begin
                to_cnt++;
                if (first_to == 0) first_to = k;
            end
            if (if2.OK !== 2'b00) ok_seen = 1;
        end
        chk("to cycle", first_to, 9);
        chk("to width", to_cnt, 1);
        chk("to ok never", ok_seen, 0);
        chk("to led clear", if2.LED, 0);

        // last latch and timeout condition coincide: deal wins
        do_reset();
        if2.READY = 2'b01;
        step();
        if2.READY = 2'b00;
        repeat (6) step();
        if2.READY = 2'b10;
        step();
        if2.READY = 2'b00;
        step();
        chk("race ok", if2.OK, 2'b11);
        chk("race no timeout", if2.TIMEOUT, 0);
        chk("race num", if2.NUM, 3);
        step();
        chk("race hold ok", if2.OK, 2'b11);
        chk("race still no timeout", if2.TIMEOUT, 0);
        if2.CLR = 1'b1;
        step();
        if2.CLR = 1'b0;
        chk("race clr ok", if2.OK, 0);

        // four players, twenty rounds; roll advances by 7 per round
        do_reset();
        prev_num  = 0;
        wrap_seen = 0;
        for (int r = 0; r < 20; r++) begin
            for (int p = 0; p < 4; p++) begin
                if3.READY = 4'b0001 << p;
                step();
                if3.READY = 4'b0000;
                chk($sformatf("r%0d p%0d ok early", r, p), if3.OK, 0);
            end
            step();
            chk($sformatf("r%0d ok", r), if3.OK, 4'b1111);
            chk($sformatf("r%0d num", r), if3.NUM, ((4 + 7 * r) % 6) + 1);
            chk($sformatf("r%0d num range", r),
                (if3.NUM >= 4'd1) && (if3.NUM <= 4'd6), 1);
            if (prev_num == 6 && if3.NUM == 4'd1) wrap_seen = 1;
            prev_num = int'(if3.NUM);
            step();
            chk($sformatf("r%0d hold", r), if3.OK, 4'b1111);
            if3.CLR = 1'b1;
            step();
            if3.CLR = 1'b0;
            chk($sformatf("r%0d clr", r), if3.OK, 0);
            step();
            step();
        end
        chk("roll wrap", wrap_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
